// File: rtl/sync_decoder_pkg.sv
// Shared definitions for the sync-line pulse decoder: event word layout and FSM states.
package sync_decoder_pkg;

  localparam int FRAME_W = 32;
  localparam int WIDTH_W = 16;
  localparam int INTV_W  = 16;
  localparam int EVT_W   = FRAME_W + WIDTH_W + INTV_W;

  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [WIDTH_W-1:0] width;
    logic [INTV_W-1:0]  interval;
  } evt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RISE_DEB = 3'd1,
    ST_HIGH     = 3'd2,
    ST_FALL_DEB = 3'd3,
    ST_STUCK    = 3'd4
  } state_e;

endpackage

// File: rtl/sync_evt_fifo.sv
// First-word-fall-through event buffer; a write into a full buffer only lands
// when the head is popped in the same cycle, otherwise it is reported as dropped.
module sync_evt_fifo
  import sync_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [EVT_W-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [EVT_W-1:0] rd_data,
  output logic             wr_ok,
  output logic             wr_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full;
  logic             pop;

  // Handshake decode, pointer/occupancy next state; head word reads as zero when empty
  always_comb begin
    full     = (count_q == FULL_CNT);
    rd_valid = (count_q != '0);
    pop      = rd_valid && rd_en;
    wr_ok    = wr_en && (!full || pop);
    wr_drop  = wr_en && full && !pop;
    rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW + 1)'(wr_ok) - (AW + 1)'(pop);
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while unoccupied so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sync_decoder.sv
// Debounces the returning sync line, measures each high pulse in frames and the
// frame distance between accepted rising edges, and queues one event per pulse.
module sync_decoder
  import sync_decoder_pkg::*;
#(
  parameter int DEB        = 16,
  parameter int MAX_W      = 25000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frame_No,
  input  logic        sync_in,
  output logic        evt_tvalid,
  input  logic        evt_tready,
  output logic [31:0] evt_frame,
  output logic [15:0] evt_width,
  output logic [15:0] evt_interval,
  output logic [15:0] pulse_cnt,
  output logic        err_overflow,
  output logic        err_stuck
);

  localparam int DW = $clog2(DEB + 1);
  localparam logic [DW-1:0]      DEB_LAST = DW'(DEB - 1);
  localparam logic [WIDTH_W-1:0] MAX_WV   = WIDTH_W'(MAX_W);

  function automatic logic [INTV_W-1:0] sat_inc(input logic [INTV_W-1:0] v, input logic en);
    logic [INTV_W-1:0] r;
    r = v;
    if (en && (v != '1)) r = v + INTV_W'(1);
    return r;
  endfunction

  logic sync_meta_q, sync_meta_d, sync_q, sync_d;
  logic fr0_q, fr0_d, fr1_q, fr1_d, frame_pulse_q, frame_pulse_d;

  state_e             state_q;
  logic [DW-1:0]      deb_q;
  logic [WIDTH_W-1:0] width_q, width_nxt;
  logic [INTV_W-1:0]  intv_q, intv_lat_q;
  logic [FRAME_W-1:0] rise_frame_q;
  logic               first_q, armed_q, err_stuck_q;
  logic               wr_q;
  logic [EVT_W-1:0]   wr_data_q;

  logic               fifo_valid, fifo_wr_ok, fifo_drop;
  logic [EVT_W-1:0]   fifo_data;
  evt_t               head;
  logic [15:0]        pulse_cnt_q, pulse_cnt_d;
  logic               err_overflow_q, err_overflow_d;

  // Synchronizer and frame-edge detector next state
  always_comb begin
    sync_meta_d   = sync_in;
    sync_d        = sync_meta_q;
    fr0_d         = frame_No[0];
    fr1_d         = fr0_q;
    frame_pulse_d = fr0_q ^ fr1_q;
  end

  // Synchronizer resets high so a line held high through reset never looks like a new rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q   <= 1'b1;
      sync_q        <= 1'b1;
      fr0_q         <= 1'b0;
      fr1_q         <= 1'b0;
      frame_pulse_q <= 1'b0;
    end else begin
      sync_meta_q   <= sync_meta_d;
      sync_q        <= sync_d;
      fr0_q         <= fr0_d;
      fr1_q         <= fr1_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  // Width including the frame edge of the current cycle, so the emit cycle is counted
  always_comb begin
    width_nxt = width_q + WIDTH_W'(frame_pulse_q);
  end

  // Debounce / measurement FSM with its counters and the registered event write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      deb_q        <= '0;
      width_q      <= '0;
      intv_q       <= '0;
      intv_lat_q   <= '0;
      rise_frame_q <= '0;
      first_q      <= 1'b1;
      armed_q      <= 1'b0;
      err_stuck_q  <= 1'b0;
      wr_q         <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      wr_q   <= 1'b0;
      intv_q <= sat_inc(intv_q, frame_pulse_q);
      case (state_q)
        ST_IDLE: begin
          if (!sync_q) armed_q <= 1'b1;
          if (sync_q && armed_q) begin
            state_q <= ST_RISE_DEB;
            deb_q   <= DW'(1);
          end
        end
        ST_RISE_DEB: begin
          if (!sync_q) begin
            state_q <= ST_IDLE;
          end else if (deb_q == DEB_LAST) begin
            state_q      <= ST_HIGH;
            rise_frame_q <= frame_No;
            width_q      <= '0;
            intv_lat_q   <= first_q ? '0 : sat_inc(intv_q, frame_pulse_q);
            intv_q       <= '0;
            first_q      <= 1'b0;
          end else begin
            deb_q <= deb_q + DW'(1);
          end
        end
        ST_HIGH: begin
          width_q <= width_nxt;
          if (width_nxt == MAX_WV) begin
            state_q     <= ST_STUCK;
            err_stuck_q <= 1'b1;
            deb_q       <= '0;
          end else if (!sync_q) begin
            state_q <= ST_FALL_DEB;
            deb_q   <= DW'(1);
          end
        end
        ST_FALL_DEB: begin
          width_q <= width_nxt;
          if (width_nxt == MAX_WV) begin
            state_q     <= ST_STUCK;
            err_stuck_q <= 1'b1;
            deb_q       <= '0;
          end else if (sync_q) begin
            state_q <= ST_HIGH;
          end else if (deb_q == DEB_LAST) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b1;
            wr_data_q <= {rise_frame_q, width_nxt, intv_lat_q};
          end else begin
            deb_q <= deb_q + DW'(1);
          end
        end
        ST_STUCK: begin
          if (sync_q) begin
            deb_q <= '0;
          end else if (deb_q == DEB_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            deb_q <= deb_q + DW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_q),
    .wr_data (wr_data_q),
    .rd_en   (evt_tready),
    .rd_valid(fifo_valid),
    .rd_data (fifo_data),
    .wr_ok   (fifo_wr_ok),
    .wr_drop (fifo_drop)
  );

  // Status next state and output unpacking
  always_comb begin
    pulse_cnt_d    = pulse_cnt_q + 16'(fifo_wr_ok);
    err_overflow_d = err_overflow_q | fifo_drop;
    head           = fifo_data;
    evt_tvalid     = fifo_valid;
    evt_frame      = head.frame;
    evt_width      = head.width;
    evt_interval   = head.interval;
    pulse_cnt      = pulse_cnt_q;
    err_overflow   = err_overflow_q;
    err_stuck      = err_stuck_q;
  end

  // Event counter and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt_q    <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      pulse_cnt_q    <= pulse_cnt_d;
      err_overflow_q <= err_overflow_d;
    end
  end

endmodule

// File: tb/tb_sync_decoder.sv
// Bench for sync_decoder: frame-aligned pulses with random lengths, predicted
// events kept in a queue and compared at every consumer handshake.
module tb_sync_decoder;

  localparam int DEB   = 16;
  localparam int MAX_W = 600;
  localparam int DEPTH = 4;
  localparam int CPF   = 4;                       // clocks per frame
  localparam int LAG   = (DEB + 2 - 1) / CPF;      // frames elapsed before the rise is accepted

  logic        clk = 1'b0;
  logic        rst, sync_in, evt_tready;
  logic [31:0] frame_no;
  logic        evt_tvalid, err_overflow, err_stuck;
  logic [31:0] evt_frame;
  logic [15:0] evt_width, evt_interval, pulse_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] f;
    logic [15:0] w;
    logic [15:0] i;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          exp_cnt;
  bit          exp_ovf, exp_stuck, have_rise;
  logic [31:0] last_rise;
  bit          hold_p;
  logic [63:0] hold_d;

  sync_decoder #(.DEB(DEB), .MAX_W(MAX_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_No    (frame_no),
    .sync_in     (sync_in),
    .evt_tvalid  (evt_tvalid),
    .evt_tready  (evt_tready),
    .evt_frame   (evt_frame),
    .evt_width   (evt_width),
    .evt_interval(evt_interval),
    .pulse_cnt   (pulse_cnt),
    .err_overflow(err_overflow),
    .err_stuck   (err_stuck)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (CPF) @(posedge clk);
      #1 frame_no = frame_no + 32'd1;
    end
  endtask

  // One high pulse of nh frames followed by nl low frames; store=0 means the FIFO is expected to drop it
  task automatic pulse(input int nh, input int nl, input bit store);
    ev_t         e;
    logic [31:0] d;
    d     = frame_no - last_rise;
    e.f   = frame_no + 32'(LAG);
    e.w   = 16'(nh);
    e.i   = !have_rise ? 16'd0 : (d > 32'd65535 ? 16'hFFFF : d[15:0]);
    have_rise = 1'b1;
    last_rise = frame_no;
    if (nh >= MAX_W) exp_stuck = 1'b1;
    else if (store) begin
      exp_q.push_back(e);
      exp_cnt++;
    end else exp_ovf = 1'b1;
    sync_in = 1'b1;
    frames(nh);
    sync_in = 1'b0;
    frames(nl);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) frames(1);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pulse_cnt"}, pulse_cnt, exp_cnt);
    chk({tag, "_err_ovf"}, err_overflow, exp_ovf);
    chk({tag, "_err_stuck"}, err_stuck, exp_stuck);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, evt_tvalid, 0);
    chk({tag, "_frame"}, evt_frame, 0);
    chk({tag, "_width"}, evt_width, 0);
    chk({tag, "_interval"}, evt_interval, 0);
    chk({tag, "_pulse_cnt"}, pulse_cnt, 0);
    chk({tag, "_err_ovf"}, err_overflow, 0);
    chk({tag, "_err_stuck"}, err_stuck, 0);
  endtask

  // Consumer side: compare each handshaken event and hold stability under backpressure
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        chk("hold_valid", evt_tvalid, 1);
        chk("hold_data", {evt_frame, evt_width, evt_interval}, hold_d);
      end
      if (evt_tvalid && evt_tready) begin
        chk("evt_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("evt_frame", evt_frame, mon_e.f);
          chk("evt_width", evt_width, mon_e.w);
          chk("evt_interval", evt_interval, mon_e.i);
        end
      end
      hold_p = evt_tvalid && !evt_tready;
      hold_d = {evt_frame, evt_width, evt_interval};
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst        = 1'b1;
    sync_in    = 1'b0;
    evt_tready = 1'b1;
    frame_no   = $urandom;
    exp_cnt    = 0;
    exp_ovf    = 1'b0;
    exp_stuck  = 1'b0;
    have_rise  = 1'b0;
    last_rise  = '0;
    frames(3);
    chk_zero("reset");
    rst = 1'b0;
    frames(10);

    // First pulse after reset: interval 0
    pulse(500, 200, 1'b1);
    wait_drain();
    chk_status("first");

    // Second rise 700 frames after the first
    pulse(150, 40, 1'b1);
    wait_drain();
    chk_status("second");

    // 8-cycle glitch is rejected
    sync_in = 1'b1;
    frames(2);
    sync_in = 1'b0;
    frames(20);
    chk_status("glitch");

    // Random pulse lengths and gaps
    for (int n = 0; n < 6; n++) begin
      pulse($urandom_range(5, 400), $urandom_range(10, 60), 1'b1);
      wait_drain();
      chk_status("random");
    end

    // Stuck pulse, then a normal pulse timed from the stuck pulse's rise
    pulse(MAX_W + 1, 20, 1'b1);
    chk_status("stuck");
    pulse(60, 20, 1'b1);
    wait_drain();
    chk_status("after_stuck");

    // Reset in the middle of a pulse
    sync_in = 1'b1;
    frames(30);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    exp_cnt   = 0;
    exp_ovf   = 1'b0;
    exp_stuck = 1'b0;
    have_rise = 1'b0;
    exp_q.delete();
    frames(2);
    rst = 1'b0;
    frames(20);
    sync_in = 1'b0;
    frames(20);
    chk_status("truncated");

    // Backpressure: six pulses into a four-entry buffer
    evt_tready = 1'b0;
    for (int n = 0; n < 6; n++) pulse(20, 12, n < DEPTH);
    chk("full_tvalid", evt_tvalid, 1);
    chk_status("overflow");
    evt_tready = 1'b1;
    wait_drain();
    frames(1);
    chk("drained_tvalid", evt_tvalid, 0);

    pulse(30, 15, 1'b1);
    wait_drain();
    chk_status("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
